// File: rtl/stage3_bblock_fetch.sv
`default_nettype none
// ============================================================================
// Module      : stage3_bblock_fetch
// Description : Accumulates a rotate-xor basic-block signature and pairs it
//               with the reference signature read from the duplicate RAM.
//               Optional macro STAGE3_CHK_COUNT_EN adds the chk_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module stage3_bblock_fetch #(
   parameter int ADDR_W  = 10,
   parameter int RAM_LAT = 1
) (
   input  logic              core_sp_clk,
   input  logic              reset,
   input  logic              pkt_start,
   input  logic              pc_valid,
   input  logic [31:0]       pc,
   input  logic [31:0]       instr,
   input  logic              is_jump,
   output logic              core_stall,
   output logic              ram_rd,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [31:0]       ram_rdata,
   output logic [31:0]       jump_bblock,
   output logic [31:0]       dupl_bblock,
   output logic              chk_valid
`ifdef STAGE3_CHK_COUNT_EN
   ,
   output logic [15:0]       chk_count
`endif
);

   localparam logic [2:0] c_lat = 3'(RAM_LAT);

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_WAIT  = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic              w_launch;
   logic              w_capture;
   logic [2:0]        r_lat_cnt;
   logic [31:0]       r_sig;
   logic [31:0]       r_hash_hold;
   logic [31:0]       w_base_sig;
   logic [31:0]       w_sig_next;
   logic [ADDR_W-1:0] r_block_idx;
   logic [ADDR_W-1:0] w_block_idx;
   logic              r_start_pending;
   logic              w_new_block;
   logic              w_unused_pc;

   // Only the word-index bits of the pc address the duplicate RAM.
   assign w_unused_pc = ^{pc[31:ADDR_W+2], pc[1:0]};

   // A block restarts on pkt_start or on the first valid pc after a check.
   assign w_new_block = pkt_start | r_start_pending;
   assign w_base_sig  = w_new_block ? 32'h0 : r_sig;
   assign w_sig_next  = {w_base_sig[26:0], w_base_sig[31:27]} ^ instr;
   assign w_block_idx = w_new_block ? pc[ADDR_W+1:2] : r_block_idx;

   always_ff @(posedge core_sp_clk) begin
      if (reset) begin
         r_state <= ST_ACCUM;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_launch     = 1'b0;
      w_capture    = 1'b0;
      case (r_state)
         ST_ACCUM: begin
            if (pc_valid && is_jump) begin
               w_launch     = 1'b1;
               w_state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_lat_cnt == c_lat) begin
               w_capture    = 1'b1;
               w_state_next = ST_ACCUM;
            end
         end
         default: w_state_next = ST_ACCUM;
      endcase
   end

   always_ff @(posedge core_sp_clk) begin
      if (reset) begin
         core_stall      <= 1'b0;
         ram_rd          <= 1'b0;
         ram_addr        <= '0;
         jump_bblock     <= 32'h0;
         dupl_bblock     <= 32'h0;
         chk_valid       <= 1'b0;
         r_lat_cnt       <= 3'd0;
         r_sig           <= 32'h0;
         r_hash_hold     <= 32'h0;
         r_block_idx     <= '0;
         r_start_pending <= 1'b0;
      end else begin
         ram_rd    <= 1'b0;
         chk_valid <= 1'b0;
         if (r_state == ST_ACCUM) begin
            if (pc_valid) begin
               r_sig           <= w_sig_next;
               r_block_idx     <= w_block_idx;
               r_start_pending <= 1'b0;
            end
            if (w_launch) begin
               r_hash_hold <= w_sig_next;
               ram_addr    <= w_block_idx;
               ram_rd      <= 1'b1;
               core_stall  <= 1'b1;
               r_lat_cnt   <= 3'd0;
            end
         end else begin
            r_lat_cnt <= r_lat_cnt + 3'd1;
            // Both halves of the pair change together so stage4 never sees a stale mix.
            if (w_capture) begin
               jump_bblock     <= r_hash_hold;
               dupl_bblock     <= ram_rdata;
               chk_valid       <= 1'b1;
               core_stall      <= 1'b0;
               r_sig           <= 32'h0;
               r_start_pending <= 1'b1;
            end
         end
      end
   end

`ifdef STAGE3_CHK_COUNT_EN
   always_ff @(posedge core_sp_clk) begin
      if (reset) begin
         chk_count <= 16'h0;
      end else if (w_capture) begin
         if (chk_count != 16'hFFFF) begin
            chk_count <= chk_count + 16'h1;
         end
      end else if (r_state == ST_ACCUM && pc_valid && pkt_start) begin
         chk_count <= 16'h0;
      end
   end
`else
   // Check counter not built.
`endif

endmodule
`default_nettype wire

// File: tb/tb_stage3_bblock_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage3_bblock_fetch
// Description : Scoreboard bench for stage3_bblock_fetch with a latency RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage3_bblock_fetch;

   localparam int ADDR_W = 10;
   localparam int LAT    = 3;

   logic              core_sp_clk = 1'b0;
   logic              reset       = 1'b1;
   logic              pkt_start   = 1'b0;
   logic              pc_valid    = 1'b0;
   logic [31:0]       pc          = 32'h0;
   logic [31:0]       instr       = 32'h0;
   logic              is_jump     = 1'b0;
   logic              core_stall;
   logic              ram_rd;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_rdata;
   logic [31:0]       jump_bblock;
   logic [31:0]       dupl_bblock;
   logic              chk_valid;

   always #5 core_sp_clk = ~core_sp_clk;

   stage3_bblock_fetch #(.ADDR_W(ADDR_W), .RAM_LAT(LAT)) dut (
      .core_sp_clk (core_sp_clk),
      .reset       (reset),
      .pkt_start   (pkt_start),
      .pc_valid    (pc_valid),
      .pc          (pc),
      .instr       (instr),
      .is_jump     (is_jump),
      .core_stall  (core_stall),
      .ram_rd      (ram_rd),
      .ram_addr    (ram_addr),
      .ram_rdata   (ram_rdata),
      .jump_bblock (jump_bblock),
      .dupl_bblock (dupl_bblock),
      .chk_valid   (chk_valid)
   );

   // Duplicate RAM: data appears LAT cycles after the read strobe, noise otherwise.
   logic [31:0] mem   [0:(1<<ADDR_W)-1];
   logic [31:0] rpipe [LAT];
   always @(posedge core_sp_clk) begin
      rpipe[0] <= ram_rd ? mem[ram_addr] : $urandom;
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
   end
   assign ram_rdata = rpipe[LAT-1];

   typedef struct {
      logic [31:0] j;
      logic [31:0] d;
   } exp_t;

   exp_t              exp_q  [$];
   logic [ADDR_W-1:0] addr_q [$];
   int                errors = 0;
   int                checks = 0;

   // Reference model: the block is a list of instruction words.
   logic [31:0]       blk [$];
   logic [ADDR_W-1:0] blk_idx = '0;
   bit                pending = 1'b0;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic consume(input bit st, input bit jmp, input logic [31:0] p,
                          input logic [31:0] ins, input int mode);
      logic [31:0] s;
      if (st || pending) begin
         blk.delete();
         blk_idx = p[ADDR_W+1:2];
         pending = 1'b0;
      end
      blk.push_back(ins);
      if (jmp) begin
         s = 32'h0;
         foreach (blk[i]) s = {s[26:0], s[31:27]} ^ blk[i];
         if (mode == 1) mem[blk_idx] = s;
         if (mode == 2) mem[blk_idx] = 32'hDEADBEEF;
         exp_q.push_back('{j: s, d: mem[blk_idx]});
         addr_q.push_back(blk_idx);
         blk.delete();
         pending = 1'b1;
      end
   endtask

   // Called #1 after a clock edge; returns #1 after the edge that sampled the inputs.
   task automatic issue(input bit v, input bit st, input bit jmp, input logic [31:0] p,
                        input logic [31:0] ins, input int mode);
      int guard = 0;
      while (core_stall) begin
         pc_valid  = 1'($urandom);
         pkt_start = 1'($urandom);
         is_jump   = 1'($urandom);
         pc        = $urandom;
         instr     = $urandom;
         @(posedge core_sp_clk); #1;
         guard++;
         if (guard > 20) begin
            chk32("stall_timeout", 32'(guard), 32'(LAT + 1));
            break;
         end
      end
      pc_valid  = v;
      pkt_start = st;
      is_jump   = jmp;
      pc        = p;
      instr     = ins;
      if (v) consume(st, jmp, p, ins, mode);
      @(posedge core_sp_clk); #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      pc_valid  = 1'b0;
      pkt_start = 1'b0;
      is_jump   = 1'b0;
      repeat (2) @(posedge core_sp_clk);
      #1;
      blk.delete();
      blk_idx = '0;
      pending = 1'b0;
      reset   = 1'b0;
      chk32("rst_core_stall", 32'(core_stall), 32'h0);
      chk32("rst_ram_rd", 32'(ram_rd), 32'h0);
      chk32("rst_ram_addr", 32'(ram_addr), 32'h0);
      chk32("rst_jump_bblock", jump_bblock, 32'h0);
      chk32("rst_dupl_bblock", dupl_bblock, 32'h0);
      chk32("rst_chk_valid", 32'(chk_valid), 32'h0);
   endtask

   // Monitor: pops expectations whenever the DUT presents a pair or a read.
   initial begin
      logic [31:0] last_j = 32'h0;
      logic [31:0] last_d = 32'h0;
      bit          prev_rd = 1'b0;
      int          stall_n = 0;
      exp_t        e;
      forever begin
         @(negedge core_sp_clk);
         if (reset) begin
            exp_q.delete();
            addr_q.delete();
            last_j  = 32'h0;
            last_d  = 32'h0;
            prev_rd = 1'b0;
            stall_n = 0;
         end else begin
            if (chk_valid) begin
               if (exp_q.size() == 0) begin
                  chk32("chk_valid_unexpected", 32'(chk_valid), 32'h0);
               end else begin
                  e = exp_q.pop_front();
                  chk32("jump_bblock", jump_bblock, e.j);
                  chk32("dupl_bblock", dupl_bblock, e.d);
                  last_j = e.j;
                  last_d = e.d;
               end
            end else begin
               chk32("jump_hold", jump_bblock, last_j);
               chk32("dupl_hold", dupl_bblock, last_d);
            end
            if (ram_rd) begin
               chk32("ram_rd_single", 32'(prev_rd), 32'h0);
               if (addr_q.size() == 0) chk32("ram_rd_unexpected", 32'(ram_rd), 32'h0);
               else chk32("ram_addr", 32'(ram_addr), 32'(addr_q.pop_front()));
            end
            prev_rd = ram_rd;
            if (core_stall) begin
               stall_n++;
            end else if (stall_n != 0) begin
               chk32("stall_len", 32'(stall_n), 32'(LAT + 1));
               stall_n = 0;
            end
         end
      end
   end

   initial begin
      logic [31:0] p;
      int          guard;
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
      @(posedge core_sp_clk); #1;
      do_reset();

      // Matching block at 0x100 (index 0x40), then the same block with a bad reference.
      issue(1, 1, 0, 32'h100, 32'h11111111, 0);
      issue(1, 0, 0, 32'h104, 32'h22222222, 0);
      issue(1, 0, 1, 32'h108, 32'h00000001, 1);
      issue(1, 1, 0, 32'h100, 32'h11111111, 0);
      issue(1, 0, 0, 32'h104, 32'h22222222, 0);
      issue(1, 0, 1, 32'h108, 32'h00000001, 2);

      // Back-to-back single-instruction blocks at distinct addresses.
      issue(1, 0, 1, 32'h200, 32'hCAFEF00D, 1);
      issue(1, 0, 1, 32'h300, 32'h12345678, 0);
      issue(0, 0, 0, 32'h0, 32'h0, 0);

      // Reset in the cycle after the read strobe; the late data must be dropped.
      issue(1, 1, 1, 32'h500, 32'hA5A5A5A5, 1);
      @(posedge core_sp_clk); #1;
      do_reset();
      repeat (6) issue(0, 0, 0, 32'h0, 32'h0, 0);

      // Randomized traffic.
      p = 32'h1000;
      for (int n = 0; n < 300; n++) begin
         issue(1'($urandom % 4 != 0), 1'($urandom % 12 == 0), 1'($urandom % 5 == 0),
               p, $urandom, int'($urandom % 2));
         p = p + 32'h4;
      end
      issue(0, 0, 0, 32'h0, 32'h0, 0);

      guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin
         @(posedge core_sp_clk); #1;
         guard++;
      end
      if (exp_q.size() != 0) chk32("drain_timeout", 32'(exp_q.size()), 32'h0);
      repeat (3) @(posedge core_sp_clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
